// File: rtl/sd_block_buffer_ctrl.sv
// Buffers one SD block: fills memory from the SPI byte stream, then drains it
// downstream in write order through a registered-output memory bank.
module sd_block_buffer_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 512,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_write,
  output logic                  mem_read,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  block_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_DRAIN_RD, S_DRAIN_OUT, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              w_in_xfer;

  // abort suppresses the write and the count in the same cycle
  assign w_in_xfer = (r_state == S_FILL) && in_valid && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else if (abort) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_state <= S_FILL;
          r_cnt   <= '0;
        end
        S_FILL: if (w_in_xfer) begin
          if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_state <= S_DRAIN_RD;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DRAIN_RD: r_state <= S_DRAIN_OUT;
        S_DRAIN_OUT: if (out_ready) begin
          if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_state <= S_DONE;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_state <= S_DRAIN_RD;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Memory data_out only changes on a read, so out_data holds through a stall.
  assign in_ready   = (r_state == S_FILL) && !abort;
  assign mem_write  = w_in_xfer;
  assign mem_wdata  = (r_state == S_FILL) ? in_data : '0;
  assign mem_read   = (r_state == S_DRAIN_RD);
  assign mem_addr   = r_cnt;
  assign out_valid  = (r_state == S_DRAIN_OUT);
  assign out_data   = (r_state == S_DRAIN_OUT) ? mem_rdata : '0;
  assign busy       = (r_state != S_IDLE);
  assign block_done = (r_state == S_DONE);

endmodule

// File: tb/tb_sd_block_buffer_ctrl.sv
// Directed bench for sd_block_buffer_ctrl with a behavioural 512-byte memory bank.
module tb_sd_block_buffer_ctrl;
  localparam int DW = 8;
  localparam int DEPTH = 512;
  localparam int AW = 9;

  logic          clk, rst_n, start, abort, in_valid, out_ready;
  logic [DW-1:0] in_data, mem_wdata, mem_rdata, out_data;
  logic [AW-1:0] mem_addr;
  logic          in_ready, mem_write, mem_read, out_valid, busy, block_done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic prv_rd = 1'b0;

  sd_block_buffer_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_addr(mem_addr), .mem_write(mem_write), .mem_read(mem_read),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .block_done(block_done)
  );

  // memory bank: registered read port, output holds while read is low
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
    if (mem_read)  mem_rdata <= mem[mem_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("rd_wr_exclusive", {31'd0, mem_read & mem_write}, 32'd0);
      if (prv_rd) chk("rd_to_out_valid", {31'd0, out_valid}, 32'd1);
      if (block_done) done_cnt++;
    end
    prv_rd = rst_n && mem_read && !abort;
  end

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_in_ready", {31'd0, in_ready}, 32'd1);
    chk("start_addr", {23'd0, mem_addr}, 32'd0);
  endtask

  task automatic fill(input logic [7:0] off, input bit gaps, input int abort_at, input int start_at);
    for (int k = 0; k < DEPTH; k++) begin
      if (gaps) begin
        int n;
        n = int'($urandom_range(0, 2));
        for (int g = 0; g < n; g++) begin
          in_valid = 1'b0;
          #1;
          chk("gap_no_write", {31'd0, mem_write}, 32'd0);
          chk("gap_in_ready", {31'd0, in_ready}, 32'd1);
          tick();
        end
      end
      in_valid = 1'b1;
      in_data  = 8'(k) + off;
      if (k == abort_at) abort = 1'b1;
      if (k == start_at) start = 1'b1;
      #1;
      if (k == abort_at) begin
        chk("abort_no_write", {31'd0, mem_write}, 32'd0);
        tick();
        abort = 1'b0;
        in_valid = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
        chk("abort_block_done", {31'd0, block_done}, 32'd0);
        return;
      end
      if (k == start_at + 1) chk("start_ignored_addr", {23'd0, mem_addr}, k);
      if (k == DEPTH - 1) begin
        chk("last_write", {31'd0, mem_write}, 32'd1);
        chk("last_addr", {23'd0, mem_addr}, 32'd511);
      end
      tick();
      start = 1'b0;
    end
    in_valid = 1'b0;
    chk("fill_end_in_ready", {31'd0, in_ready}, 32'd0);
    chk("drain_rd_read", {31'd0, mem_read}, 32'd1);
    chk("drain_rd_addr", {23'd0, mem_addr}, 32'd0);
    chk("drain_rd_no_valid", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic drain(input logic [7:0] off, input int stall_at, input int rst_at);
    for (int k = 0; k < DEPTH; k++) begin
      int t;
      t = 0;
      while (!out_valid && t < 8) begin
        tick();
        t++;
      end
      chk("out_valid_wait", {31'd0, out_valid}, 32'd1);
      chk("out_data", {24'd0, out_data}, {24'd0, 8'(k) + off});
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
        chk("rst_mem_addr", {23'd0, mem_addr}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_block_done", {31'd0, block_done}, 32'd0);
        return;
      end
      if (k == stall_at) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          chk("stall_valid", {31'd0, out_valid}, 32'd1);
          chk("stall_data", {24'd0, out_data}, {24'd0, 8'(k) + off});
          chk("stall_no_read", {31'd0, mem_read}, 32'd0);
          tick();
        end
        out_ready = 1'b1;
      end
      tick();
    end
    chk("done_pulse", {31'd0, block_done}, 32'd1);
    chk("done_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("done_fall", {31'd0, block_done}, 32'd0);
    chk("busy_fall", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #2;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_mem_write", {31'd0, mem_write}, 32'd0);
    chk("reset_mem_read", {31'd0, mem_read}, 32'd0);
    chk("reset_block_done", {31'd0, block_done}, 32'd0);
    chk("reset_mem_addr", {23'd0, mem_addr}, 32'd0);
    chk("reset_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    chk("reset_out_data", {24'd0, out_data}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // block 1: back-to-back fill, unstalled drain
    do_start();
    fill(8'h00, 1'b0, -1, -1);
    drain(8'h00, -1, -1);
    chk("done_count_1", done_cnt, 1);

    // aborted fill, then a full block with gaps and a stall on byte 100
    do_start();
    fill(8'h55, 1'b0, 300, -1);
    tick();
    chk("abort_done_count", done_cnt, 1);
    do_start();
    fill(8'h00, 1'b1, -1, -1);
    drain(8'h00, 100, -1);
    chk("done_count_2", done_cnt, 2);

    // reset pulse in the middle of a drain
    do_start();
    fill(8'h33, 1'b0, -1, -1);
    drain(8'h33, -1, 50);
    chk("rst_done_count", done_cnt, 2);

    // start pulsed mid-fill must not restart the counter
    do_start();
    fill(8'h11, 1'b0, -1, 10);
    drain(8'h11, -1, -1);
    chk("done_count_3", done_cnt, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sd_block_buffer_ctrl.md
SD_BLOCK_BUFFER_CTRL -- requirements
Module: sd_block_buffer_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, byte width of stream and memory word.
REQ-002 Parameter DEPTH, default 512, bytes per block; ADDR_W = $clog2(DEPTH).
REQ-003 clk  input  1  system clock; all state changes on posedge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse that begins a block fill; honoured only in IDLE.
REQ-006 abort  input  1  synchronous abort; returns to IDLE from any state.
REQ-007 in_data  input  DATA_WIDTH  upstream byte from the SD SPI receiver.
REQ-008 in_valid  input  1  in_data valid.
REQ-009 in_ready  output  1  block accepts in_data; a transfer occurs when in_valid & in_ready.
REQ-010 mem_addr  output  ADDR_W  address to memory_bank addr.
REQ-011 mem_write  output  1  to memory_bank write.
REQ-012 mem_read  output  1  to memory_bank read.
REQ-013 mem_wdata  output  DATA_WIDTH  to memory_bank data_in.
REQ-014 mem_rdata  input  DATA_WIDTH  from memory_bank data_out, registered, valid the cycle after mem_read.
REQ-015 out_data  output  DATA_WIDTH  downstream byte.
REQ-016 out_valid  output  1  out_data valid; a transfer occurs when out_valid & out_ready.
REQ-017 out_ready  input  1  downstream accepts out_data.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 block_done  output  1  one-cycle pulse after the last byte drains.

Function
REQ-020 States: IDLE, FILL, DRAIN_RD, DRAIN_OUT, DONE.
REQ-021 IDLE: in_ready=0, out_valid=0, mem_read=0, mem_write=0; start=1 -> FILL, address counter <= 0.
REQ-022 FILL: in_ready=1; mem_wdata=in_data, mem_addr=counter; mem_write = in_valid combinationally.
REQ-023 FILL, on each transfer: counter <= counter+1; in_valid=0 holds state and counter.
REQ-024 FILL, transfer at counter==DEPTH-1: write the byte, counter <= 0, -> DRAIN_RD; in_ready=0 from the next cycle.
REQ-025 DRAIN_RD: mem_read=1, mem_addr=counter, out_valid=0; unconditionally -> DRAIN_OUT next cycle.
REQ-026 DRAIN_OUT: out_valid=1, out_data=mem_rdata, mem_read=0, mem_write=0; memory output is stable because read is low.
REQ-027 DRAIN_OUT, out_ready=0: hold state, counter and out_data.
REQ-028 DRAIN_OUT, out_ready=1 and counter<DEPTH-1: counter <= counter+1, -> DRAIN_RD; peak drain throughput is 1 byte per 2 cycles.
REQ-029 DRAIN_OUT, out_ready=1 and counter==DEPTH-1: counter <= 0, -> DONE.
REQ-030 DONE: block_done=1 for exactly one cycle; -> IDLE.
REQ-031 mem_write and mem_read are never high in the same cycle.
REQ-032 Counter is ADDR_W bits and never wraps silently; it terminates at DEPTH-1 in both phases.
REQ-033 start outside IDLE is ignored; start and abort in the same cycle: abort wins.
REQ-034 abort=1 in any state: -> IDLE, counter <= 0, no mem_write that cycle, block_done not asserted.
REQ-035 Bytes leave in write order: byte k of the fill appears as the k-th out transfer.

Reset
REQ-036 rst_n=0 immediately forces state IDLE, counter 0, and in_ready, out_valid, mem_read, mem_write, busy, block_done all 0; mem_addr, mem_wdata and out_data read 0.
REQ-037 rst_n deassertion mid-fill or mid-drain restarts in IDLE; the partial block is discarded and start is required.

Verification (bench instantiates memory_bank with DEPTH=512)
REQ-038 start, 512 bytes value i mod 256 with in_valid held high, out_ready held high -> 512 out transfers with values 0..255,0..255; block_done pulses once; busy falls the same cycle block_done falls.
REQ-039 Fill with random in_valid gaps -> no write while in_valid=0; last write at mem_addr=511; in_ready falls after the 512th byte.
REQ-040 Drain with out_ready low for 5 cycles on byte 100 -> out_valid stays 1 and out_data stays 100 throughout; no mem_read during the stall.
REQ-041 abort at fill byte 300 -> IDLE next cycle with busy=0 and no block_done; a new start and full block then drain correctly from address 0.
REQ-042 rst_n pulsed low during drain byte 50 -> all outputs 0 while rst_n=0; IDLE afterwards; start is ignored while a block is in progress.
REQ-043 Assertion checked every cycle: never (mem_read & mem_write); the cycle between DRAIN_RD and out_valid is exactly 1.
